counter_ctrl: RTL and testbench

- Command-driven sequencer that drives an up/down counter's control inputs: load_n, data_load, ce, up_down.
- Accepts a command {start, target, direction} over a valid/ready handshake. It loads start, enables counting until count_out equals target, then pulses done.
- Sits between a test or control master and the counter. It is the driving end of the counter's control interface.

---
 rtl/counter_ctrl_pkg.sv | 13 +
 rtl/counter_ctrl.sv | 134 +++++++++++++
 tb/tb_counter_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter_ctrl command sequencer.
package counter_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/counter_ctrl.sv
// Command-driven sequencer that loads an up/down counter and runs it to a target value.
// Optional saturation stop (no wrap) when COUNTER_CTRL_SAT_EN is defined.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             cmd_up,
    input  logic             cmd_abort,
    input  logic [WIDTH-1:0] count_out,
    input  logic             zero,
    input  logic             max_count,
    output logic             load_n,
    output logic [WIDTH-1:0] data_load,
    output logic             ce,
    output logic             up_down,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             saturated
);

    ctrl_state_e      state;
    ctrl_state_e      next_state;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] target_q;
    logic             up_q;
    logic             at_target;
    logic             sat_hit;
    logic             in_cmd;

    assign at_target = (count_out == target_q);
    assign in_cmd    = (state == LOAD) || (state == RUN);

`ifdef COUNTER_CTRL_SAT_EN
    // Counter sits at its rail in the counting direction and the target lies beyond it.
    assign sat_hit = (state == RUN) && !at_target &&
                     ((up_q && max_count) || (!up_q && zero));
`else
    logic unused_flags;
    assign unused_flags = zero ^ max_count;
    assign sat_hit      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (cmd_valid) next_state = LOAD;
            LOAD: next_state = cmd_abort ? IDLE : RUN;
            RUN: begin
                if (cmd_abort) begin
                    next_state = IDLE;
                end else if (at_target || sat_hit) begin
                    next_state = FIN;
                end
            end
            FIN:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counter-side and handshake outputs decoded from state; ce must react to count_out in-cycle
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        load_n    = 1'b1;
        data_load = '0;
        ce        = 1'b0;
        up_down   = 1'b1;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            LOAD: begin
                load_n    = cmd_abort;
                data_load = start_q;
            end
            RUN: begin
                up_down = up_q;
                ce      = !cmd_abort && !at_target && !sat_hit;
            end
            FIN: begin
                ce = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Command register, captured on the accepting handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q  <= '0;
            target_q <= '0;
            up_q     <= 1'b1;
        end else if ((state == IDLE) && cmd_valid) begin
            start_q  <= cmd_start;
            target_q <= cmd_target;
            up_q     <= cmd_up;
        end
    end

    // Completion pulses: high for exactly the cycle after the deciding edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            aborted   <= 1'b0;
            saturated <= 1'b0;
        end else begin
            done      <= (state == RUN) && !cmd_abort && at_target;
            aborted   <= in_cmd && cmd_abort;
            saturated <= (state == RUN) && !cmd_abort && sat_hit;
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Closed-loop directed bench: counter_ctrl driving a simple up/down counter.
module tb_counter_ctrl;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cnt_rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_start = '0;
    logic [W-1:0] cmd_target = '0;
    logic         cmd_up = 1'b1;
    logic         cmd_abort = 1'b0;
    logic [W-1:0] count_out;
    logic         zero;
    logic         max_count;
    logic         load_n;
    logic [W-1:0] data_load;
    logic         ce;
    logic         up_down;
    logic         busy;
    logic         done;
    logic         aborted;
    logic         saturated;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_target(cmd_target), .cmd_up(cmd_up),
        .cmd_abort(cmd_abort),
        .count_out(count_out), .zero(zero), .max_count(max_count),
        .load_n(load_n), .data_load(data_load), .ce(ce), .up_down(up_down),
        .busy(busy), .done(done), .aborted(aborted), .saturated(saturated)
    );

    // The attached counter: synchronous active-low load, count when enabled
    always_ff @(posedge clk or posedge cnt_rst) begin
        if (cnt_rst)     count_out <= '0;
        else if (!load_n) count_out <= data_load;
        else if (ce)      count_out <= up_down ? count_out + W'(1) : count_out - W'(1);
    end
    assign zero      = (count_out == '0);
    assign max_count = (count_out == '1);

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a command, then follow it until done/saturated, counting load and ce cycles.
    task automatic run_cmd(input logic [W-1:0] s, input logic [W-1:0] t, input logic up,
                           output int k, output int loads, output int ces,
                           output int got_done, output int got_sat);
        cmd_start = s; cmd_target = t; cmd_up = up; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        k = 0; loads = 0; ces = 0; got_done = 0; got_sat = 0;
        while (k < 40) begin
            if (!load_n) begin
                loads++;
                if (data_load !== s) chk("data_load", int'(data_load), int'(s));
            end
            if (ce) ces++;
            if (done || saturated) begin
                got_done = int'(done);
                got_sat  = int'(saturated);
                break;
            end
            step();
            k++;
        end
        if (k >= 40) chk("timeout", k, 0);
    endtask

    int k, loads, ces, gd, gs;

    initial begin
        // Reset values
        #2;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_load_n", int'(load_n), 1);
        chk("rst_ce", int'(ce), 0);
        chk("rst_up_down", int'(up_down), 1);
        chk("rst_data_load", int'(data_load), 0);
        chk("rst_pulses", int'({done, aborted, saturated}), 0);
        step();
        rst = 1'b0; cnt_rst = 1'b0;
        step();

        // 3 -> 7 up
        run_cmd(4'd3, 4'd7, 1'b1, k, loads, ces, gd, gs);
        chk("up_latency", k, 6);
        chk("up_loads", loads, 1);
        chk("up_ce", ces, 4);
        chk("up_done", gd, 1);
        chk("up_busy_fin", int'(busy), 1);
        chk("up_count", int'(count_out), 7);
        step();
        chk("up_done_1cyc", int'(done), 0);
        chk("up_ready_after", int'(cmd_ready), 1);

        // 2 -> 14 down: wraps without saturation, stops at 0 with it
        run_cmd(4'd2, 4'd14, 1'b0, k, loads, ces, gd, gs);
`ifdef COUNTER_CTRL_SAT_EN
        chk("dn_latency", k, 4);
        chk("dn_ce", ces, 2);
        chk("dn_done", gd, 0);
        chk("dn_sat", gs, 1);
        chk("dn_count", int'(count_out), 0);
`else
        chk("dn_latency", k, 6);
        chk("dn_ce", ces, 4);
        chk("dn_done", gd, 1);
        chk("dn_sat", gs, 0);
        chk("dn_count", int'(count_out), 14);
`endif
        step();

        // start == target
        run_cmd(4'd9, 4'd9, 1'b1, k, loads, ces, gd, gs);
        chk("eq_latency", k, 2);
        chk("eq_ce", ces, 0);
        chk("eq_done", gd, 1);
        chk("eq_count", int'(count_out), 9);
        step();

        // Abort in RUN at count 5
        cmd_start = 4'd0; cmd_target = 4'd12; cmd_up = 1'b1; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        k = 0;
        while (count_out != 4'd5 && k < 20) begin step(); k++; end
        chk("ab_reach5", k, 6);
        cmd_valid = 1'b1;
        cmd_abort = 1'b1;
        #1;
        chk("ab_ce", int'(ce), 0);
        chk("ab_load_n", int'(load_n), 1);
        step();
        cmd_abort = 1'b0;
        cmd_valid = 1'b0;
        chk("ab_pulse", int'(aborted), 1);
        chk("ab_done", int'(done), 0);
        chk("ab_ready", int'(cmd_ready), 1);
        chk("ab_count", int'(count_out), 5);
        step();
        chk("ab_pulse_1cyc", int'(aborted), 0);
        chk("ab_count_hold", int'(count_out), 5);

        // Async reset mid-RUN
        cmd_start = 4'd0; cmd_target = 4'd12; cmd_up = 1'b1; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step(); step(); step();
        chk("rr_busy_before", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rr_busy", int'(busy), 0);
        chk("rr_ce", int'(ce), 0);
        chk("rr_ready", int'(cmd_ready), 1);
        chk("rr_load_n", int'(load_n), 1);
        step();
        chk("rr_no_done", int'(done), 0);
        chk("rr_no_abort", int'(aborted), 0);
        rst = 1'b0;
        step();
        run_cmd(4'd1, 4'd3, 1'b1, k, loads, ces, gd, gs);
        chk("rr_next_latency", k, 4);
        chk("rr_next_done", gd, 1);
        chk("rr_next_count", int'(count_out), 3);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
